duty_step_ctrl: RTL
===================

# duty_step_ctrl

Upstream control stage for the LED PWM generator. Samples two raw push-buttons (up/down), synchronises and debounces them on a prescaled sample tick, and produces a saturating duty-cycle value with press-and-hold auto-repeat. The duty value and its update strobe feed the PWM comparator, which drives its output high while its period counter is below `duty`.

## Interface

- `TICK_DIV`, default 16000: clocks per sample tick (1 ms at 16 MHz); must be ≥ 2.
- `STABLE_TICKS`, default 10: consecutive differing ticks required to accept a new button level; must be ≥ 1.
- `REPEAT_DELAY`, default 500: ticks a button must be held after the first step before auto-repeat starts.
- `REPEAT_RATE`, default 100: ticks between auto-repeat steps.
- `DUTY_W`, default 4: width of `duty`.
- `DUTY_MAX`, default 10: upper saturation value; must be < 2^DUTY_W.
- `DUTY_INIT`, default 5: reset value of `duty`, giving 50 % duty at a PWM period of 10.

Ports:

- `CLK` input 1: single system clock (16 MHz).
- `RESET_N` input 1: asynchronous, active-low reset.
- `btn_up` input 1: raw up button, active high, asynchronous to `CLK`.
- `btn_dn` input 1: raw down button, active high, asynchronous to `CLK`.
- `duty` output DUTY_W: current duty value, range 0..DUTY_MAX, registered.
- `duty_strobe` output 1: one-cycle pulse in the first cycle `duty` holds a new value.
- `at_max` output 1: registered; high when `duty == DUTY_MAX`.
- `at_min` output 1: registered; high when `duty == 0`.

## Operation

- **Reset** (async assert, sync release by RESET_N going high):
  - `duty = DUTY_INIT`, `duty_strobe = 0`, and `at_max`/`at_min` consistent with `DUTY_INIT`.
  - Synchronisers, debounced levels, debounce counters and prescaler all cleared to 0.
  - Both FSMs in IDLE.
- **Synchroniser**: a 2-flop synchroniser per button. All logic below uses only the synchronised level.
- **Prescaler**:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - `tick` is high for the one cycle where count == TICK_DIV-1.
- **Debounce, per button**:
  - On a `tick` cycle where sync ≠ debounced level, the counter increments.
  - On a `tick` cycle where sync == debounced level, the counter clears to 0.
  - When an increment would reach STABLE_TICKS, the debounced level toggles and the counter clears.
  - Glitches shorter than STABLE_TICKS ticks are rejected.
- **FSM, per button**, with states IDLE, HOLD and REPEAT:
  - IDLE → HOLD on debounced rising edge; emit one step request. The hold counter clears.
  - HOLD: the hold counter increments on each `tick`. When it reaches REPEAT_DELAY, go to REPEAT, emit a step request and clear the counter.
  - REPEAT: the counter increments on `tick`. When it reaches REPEAT_RATE, emit a step request and clear the counter.
  - HOLD or REPEAT → IDLE on debounced low. No step is emitted on release.
- **Duty update**, evaluated each cycle from the step requests:
  - Up only: `duty+1` if `duty < DUTY_MAX`, else unchanged.
  - Down only: `duty-1` if `duty > 0`, else unchanged. There is no underflow wrap.
  - Up and down in the same cycle: both requests are discarded and `duty` is unchanged.
  - `duty_strobe` asserts only when `duty` actually changes. A saturated request produces no strobe.
- **Flags**: `at_max`/`at_min` are registered alongside `duty` and always match it.

## Timing

- A raw input edge reaches the synchronised level 2 cycles later.
- The debounced level toggles on the `tick` cycle that completes STABLE_TICKS consecutive differing ticks. The new level is visible the following cycle.
- The step request is registered 1 cycle after the debounced edge.
- `duty`, `duty_strobe`, `at_max` and `at_min` update 1 cycle after the step request.
- The first step therefore lands 2 cycles after the debounced level changes.
- While a button is held, auto-repeat steps are spaced exactly REPEAT_RATE×TICK_DIV cycles apart. The first repeat comes REPEAT_DELAY×TICK_DIV cycles after the initial step.
- `duty_strobe` is exactly 1 cycle wide. Consecutive strobes are separated by at least TICK_DIV cycles.
- If `RESET_N` is asserted mid-hold or mid-debounce, all state clears immediately. A button still held at reset release must re-debounce from 0 and then produces an initial step; the FSM treats it as a fresh press.

## Test plan

Bench parameters: TICK_DIV=4, STABLE_TICKS=3, REPEAT_DELAY=8, REPEAT_RATE=2, DUTY_MAX=10, DUTY_INIT=5.

- **Reset**: assert `RESET_N=0` mid-operation → `duty=5`, `duty_strobe=0`, `at_max=0`, `at_min=0` asynchronously. After release, 100 idle cycles → no strobe.
- **Debounce**:
  - `btn_up` high for 2 ticks (8 cycles) then low → `duty` stays 5, no strobe.
  - `btn_up` high steadily → `duty=6` with one strobe; no further change within 32 cycles of that strobe.
- **Auto-repeat and saturation**: hold `btn_up` → `duty` goes 6 at the first step, then 7 after 32 more cycles, then 8, 9, 10 at 8-cycle spacing. It stays at 10 with `at_max=1` and no further strobes.
- **Down to zero**: hold `btn_dn` from 5 → `duty` steps down to 0 with `at_min=1`. Continued hold yields no strobe and no wrap to 15.
- **Simultaneous press**: raise `btn_up` and `btn_dn` on the same cycle from duty 5 → first steps cancel and `duty` stays 5. Release `btn_dn` → `btn_up` continues its repeat from its own hold counter.
- **Reset during hold**: hold `btn_up` in REPEAT, pulse `RESET_N` low → `duty=5`. With `btn_up` still high, exactly one step to 6 after re-debounce, then repeat resumes after the full REPEAT_DELAY.

Source files
------------

// File: rtl/duty_step_ctrl.sv
// Two-button duty-cycle controller: synchronise, debounce on a prescaled tick,
// and step a saturating duty value with press-and-hold auto-repeat.
module duty_step_ctrl #(
  parameter int unsigned TICK_DIV     = 16000,
  parameter int unsigned STABLE_TICKS = 10,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100,
  parameter int unsigned DUTY_W       = 4,
  parameter int unsigned DUTY_MAX     = 10,
  parameter int unsigned DUTY_INIT    = 5
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              btn_up,
  input  logic              btn_dn,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_strobe,
  output logic              at_max,
  output logic              at_min
);

  localparam int unsigned NBTN     = 2;
  localparam int unsigned BTN_UP   = 0;
  localparam int unsigned BTN_DN   = 1;
  localparam int unsigned TICK_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DB_W     = $clog2(STABLE_TICKS + 1);
  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_e;

  // Sample-tick prescaler; tick_d lags by one cycle so hold counting lines up
  // with the cycle in which a new debounced level first becomes visible.
  logic [TICK_W-1:0] tick_cnt;
  logic              tick_c;
  logic              tick_d;

  assign tick_c = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tick_cnt <= '0;
      tick_d   <= 1'b0;
    end else begin
      tick_cnt <= tick_c ? '0 : tick_cnt + TICK_W'(1);
      tick_d   <= tick_c;
    end
  end

  // Two-flop synchronisers for the raw buttons
  logic [NBTN-1:0] btn_raw_c;
  logic [NBTN-1:0] sync1;
  logic [NBTN-1:0] sync2;

  assign btn_raw_c = {btn_dn, btn_up};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw_c;
      sync2 <= sync1;
    end
  end

  logic [NBTN-1:0] step_req;

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    logic              db_q;
    logic [DB_W-1:0]   db_cnt;
    logic [DB_W-1:0]   db_inc_c;
    btn_state_e        state_q;
    btn_state_e        state_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic [HOLD_W-1:0] hold_inc_c;
    logic              req_q;
    logic              req_d;

    assign db_inc_c   = db_cnt + DB_W'(1);
    assign hold_inc_c = hold_q + HOLD_W'(1);

    // Debounce: level flips after STABLE_TICKS consecutive differing ticks
    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        db_q   <= 1'b0;
        db_cnt <= '0;
      end else if (tick_c) begin
        if (sync2[i] == db_q) begin
          db_cnt <= '0;
        end else if (db_inc_c == DB_W'(STABLE_TICKS)) begin
          db_q   <= ~db_q;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_inc_c;
        end
      end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        state_q <= ST_IDLE;
        hold_q  <= '0;
        req_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        req_q   <= req_d;
      end
    end

    // Press / hold / repeat sequencing; release never emits a step
    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      req_d   = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (db_q) begin
            state_d = ST_HOLD;
            hold_d  = '0;
            req_d   = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!db_q) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else if (tick_d) begin
            if (hold_inc_c == HOLD_W'(REPEAT_DELAY)) begin
              state_d = ST_REPEAT;
              hold_d  = '0;
              req_d   = 1'b1;
            end else begin
              hold_d = hold_inc_c;
            end
          end
        end
        ST_REPEAT: begin
          if (!db_q) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else if (tick_d) begin
            if (hold_inc_c == HOLD_W'(REPEAT_RATE)) begin
              hold_d = '0;
              req_d  = 1'b1;
            end else begin
              hold_d = hold_inc_c;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end
      endcase
    end

    assign step_req[i] = req_q;
  end

  // Saturating duty update; simultaneous requests cancel
  logic [DUTY_W-1:0] duty_d;
  logic              change_c;

  always_comb begin
    duty_d   = duty;
    change_c = 1'b0;
    if (step_req[BTN_UP] && !step_req[BTN_DN]) begin
      if (duty < DUTY_W'(DUTY_MAX)) begin
        duty_d   = duty + DUTY_W'(1);
        change_c = 1'b1;
      end
    end else if (step_req[BTN_DN] && !step_req[BTN_UP]) begin
      if (duty != '0) begin
        duty_d   = duty - DUTY_W'(1);
        change_c = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      duty        <= DUTY_W'(DUTY_INIT);
      duty_strobe <= 1'b0;
      at_max      <= (DUTY_INIT == DUTY_MAX);
      at_min      <= (DUTY_INIT == 0);
    end else begin
      duty        <= duty_d;
      duty_strobe <= change_c;
      at_max      <= (duty_d == DUTY_W'(DUTY_MAX));
      at_min      <= (duty_d == '0);
    end
  end

endmodule
